// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port and a per-register busy scoreboard.
// Latency: reads are combinational (same-cycle forwarding when BYPASS=1); writes and busy set/clear land on the next rising edge.
// Backpressure: none; hazard/busy outputs let the control FSM stall on RAW hazards.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   rs,
  input  logic [ADDR_W-1:0]   rt,
  input  logic [ADDR_W-1:0]   rd,
  input  logic                we,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                issue_vld,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic [DATA_W-1:0]   out_data_a,
  output logic [DATA_W-1:0]   out_data_b,
  output logic                busy_a,
  output logic                busy_b,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic wr_ok;
  logic iss_ok;
  logic rs_ok;
  logic rt_ok;
  logic fwd_a;
  logic fwd_b;

  // An address names real, mutable state: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = (int'({1'b0, a}) < NUM_REGS);
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  // Qualify the current write, issue and read addresses; detect same-cycle forwarding.
  always_comb begin
    wr_ok  = we && addr_ok(rd);
    iss_ok = issue_vld && addr_ok(issue_rd);
    rs_ok  = addr_ok(rs);
    rt_ok  = addr_ok(rt);
    fwd_a  = (BYPASS != 0) && wr_ok && (rd == rs);
    fwd_b  = (BYPASS != 0) && wr_ok && (rd == rt);
  end

  // Read ports: forwarded write data first, else stored value, else zero.
  always_comb begin
    out_data_a = '0;
    out_data_b = '0;
    if (fwd_a) begin
      out_data_a = i_data;
    end else if (rs_ok) begin
      out_data_a = regs_q[rs[IDX_W-1:0]];
    end
    if (fwd_b) begin
      out_data_b = i_data;
    end else if (rt_ok) begin
      out_data_b = regs_q[rt[IDX_W-1:0]];
    end
  end

  // Busy lookups; a forwarded writeback already resolves the hazard this cycle.
  always_comb begin
    busy_a = rs_ok && busy_q[rs[IDX_W-1:0]] && !fwd_a;
    busy_b = rt_ok && busy_q[rt[IDX_W-1:0]] && !fwd_b;
    hazard = busy_a || busy_b;
  end

  assign busy_vec = busy_q;

  // Next state: writeback stores data and clears busy; a same-cycle issue re-sets busy (newer owner wins).
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[rd[IDX_W-1:0]] = i_data;
      busy_d[rd[IDX_W-1:0]] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[issue_rd[IDX_W-1:0]] = 1'b1;
    end
  end

  // State registers with synchronous active-low reset; reset overrides any write or issue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

endmodule
